// File: rtl/booth_divider.sv
// Sequential signed divider: 2N-bit dividend by N-bit divisor, restoring radix-2
// on magnitudes, one quotient bit per clock, with saturation and divide-by-zero flags.
module booth_divider #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(2*N+1);
  localparam logic [N-1:0]   POS_SAT = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]   NEG_SAT = {1'b1, {(N-1){1'b0}}};
  localparam logic [2*N-1:0] POS_LIM = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N-1:0] NEG_LIM = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state, next_state;
  logic            load, step, finish;
  logic            sign_q, sign_r, zero_div;
  logic [2*N-1:0]  dvd_mag;
  logic [N-1:0]    dvs_mag;
  logic [N-1:0]    prem;
  logic [CW-1:0]   cnt;
  logic [N:0]      shifted;
  logic [N-1:0]    trial;
  logic            fits;

  // dvd_mag doubles as the quotient register: quotient bits shift in at the bottom
  assign shifted = {prem, dvd_mag[2*N-1]};
  assign fits    = shifted >= {1'b0, dvs_mag};
  assign trial   = shifted[N-1:0] - dvs_mag;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = (divisor == '0) ? FIN : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CW'(1)) next_state = FIN;
      end
      FIN: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_div    <= 1'b0;
      dvd_mag     <= '0;
      dvs_mag     <= '0;
      prem        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        sign_q   <= dividend[2*N-1] ^ divisor[N-1];
        sign_r   <= dividend[2*N-1];
        dvd_mag  <= dividend[2*N-1] ? -dividend : dividend;
        dvs_mag  <= divisor[N-1] ? -divisor : divisor;
        zero_div <= (divisor == '0);
        prem     <= '0;
        cnt      <= CW'(2*N);
        busy     <= 1'b1;
      end
      if (step) begin
        prem    <= fits ? trial : shifted[N-1:0];
        dvd_mag <= {dvd_mag[2*N-2:0], fits};
        cnt     <= cnt - CW'(1);
      end
      // Full 2N-bit magnitude quotient is range-checked before truncation to N bits
      if (finish) begin
        busy        <= 1'b0;
        done        <= 1'b1;
        div_by_zero <= zero_div;
        if (zero_div) begin
          overflow  <= 1'b0;
          quotient  <= '0;
          remainder <= '0;
        end else if (sign_q && dvd_mag > NEG_LIM) begin
          overflow  <= 1'b1;
          quotient  <= NEG_SAT;
          remainder <= '0;
        end else if (!sign_q && dvd_mag > POS_LIM) begin
          overflow  <= 1'b1;
          quotient  <= POS_SAT;
          remainder <= '0;
        end else begin
          overflow  <= 1'b0;
          quotient  <= sign_q ? -dvd_mag[N-1:0] : dvd_mag[N-1:0];
          remainder <= sign_r ? -prem : prem;
        end
      end
    end
  end

endmodule
